// File: rtl/token_issuer_pkg.sv
// Shared types and default widths for the token burst issuer and its gap timer.
package token_issuer_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // True when a down-counter value means "this is the final idle cycle".
    function automatic logic gap_final(input logic [GAP_W_DEF-1:0] value);
        return (value <= GAP_W_DEF'(1));
    endfunction

endpackage

// File: rtl/token_gap_timer.sv
// Loadable down-counter that times the idle gap between tokens of a burst.
module token_gap_timer #(
    parameter int GAP_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [GAP_W-1:0] load_val_i,
    input  logic             count_i,
    output logic             expired_o
);

    logic [GAP_W-1:0] count_q;
    logic [GAP_W-1:0] count_d;

    // Load wins over count; the counter saturates at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q <= GAP_W'(1));

endmodule

// File: rtl/token_burst_issuer.sv
// Producer side of the dataless token enqueue handshake: issues a commanded
// number of tokens, optionally spaced by idle gaps, with sticky abort support.
module token_burst_issuer
    import token_issuer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_cmd_valid,
    output logic             io_cmd_ready,
    input  logic [CNT_W-1:0] io_cmd_bits_count,
    input  logic [GAP_W-1:0] io_cmd_bits_gap,
    input  logic             io_abort,
    output logic             io_enq_valid,
    input  logic             io_enq_ready,
    output logic             io_done,
    output logic             io_done_aborted,
    output logic             io_busy,
    output logic [CNT_W-1:0] io_issued
);

    // Handshakes: a transfer happens on a rising clock edge where valid and
    // ready are both high; once raised, valid holds until that transfer.
    state_e           state_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] issued_q;
    logic [GAP_W-1:0] gap_q;
    logic             abort_pending_q;
    logic             enq_valid_q;
    logic             done_q;
    logic             done_aborted_q;

    logic             tok_fire;
    logic             abort_now;
    logic             last_tok;
    logic             gap_load;
    logic             gap_count;
    logic             gap_expired;

    assign tok_fire  = enq_valid_q && io_enq_ready;
    assign abort_now = abort_pending_q || io_abort;
    assign last_tok  = (remaining_q == CNT_W'(1));
    assign gap_load  = (state_q == ISSUE) && tok_fire && !last_tok && !abort_now
                       && (gap_q != '0);
    assign gap_count = (state_q == GAP);

    token_gap_timer #(
        .GAP_W(GAP_W)
    ) u_gap_timer (
        .clk_i      (clock),
        .rst_ni     (reset),
        .load_i     (gap_load),
        .load_val_i (gap_q),
        .count_i    (gap_count),
        .expired_o  (gap_expired)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            remaining_q     <= '0;
            issued_q        <= '0;
            gap_q           <= '0;
            abort_pending_q <= 1'b0;
            enq_valid_q     <= 1'b0;
            done_q          <= 1'b0;
            done_aborted_q  <= 1'b0;
        end else begin
            done_q         <= 1'b0;
            done_aborted_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    abort_pending_q <= 1'b0;
                    if (io_cmd_valid) begin
                        remaining_q <= io_cmd_bits_count;
                        gap_q       <= io_cmd_bits_gap;
                        issued_q    <= '0;
                        if (io_cmd_bits_count == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            enq_valid_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (io_abort) begin
                        abort_pending_q <= 1'b1;
                    end
                    if (tok_fire) begin
                        issued_q    <= issued_q + 1'b1;
                        remaining_q <= remaining_q - 1'b1;
                        // A pending abort lands here, after the offered token was taken.
                        if (last_tok || abort_now) begin
                            state_q         <= IDLE;
                            enq_valid_q     <= 1'b0;
                            abort_pending_q <= 1'b0;
                            done_q          <= 1'b1;
                            done_aborted_q  <= !last_tok;
                        end else if (gap_q != '0) begin
                            state_q     <= GAP;
                            enq_valid_q <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (abort_now) begin
                        state_q         <= IDLE;
                        abort_pending_q <= 1'b0;
                        done_q          <= 1'b1;
                        done_aborted_q  <= 1'b1;
                    end else if (gap_expired) begin
                        state_q     <= ISSUE;
                        enq_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    enq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign io_cmd_ready    = (state_q == IDLE);
    assign io_busy         = (state_q != IDLE);
    assign io_enq_valid    = enq_valid_q;
    assign io_done         = done_q;
    assign io_done_aborted = done_aborted_q;
    assign io_issued       = issued_q;

endmodule

// File: tb/tb_token_burst_issuer.sv
// Randomized scoreboard bench for token_burst_issuer: a driver issues bursts and
// pushes the predicted outcome, a monitor pops and checks on every io_done.
module tb_token_burst_issuer;

    localparam int CNT_W = 8;
    localparam int GAP_W = 4;

    logic             clock;
    logic             reset;
    logic             io_cmd_valid;
    logic             io_cmd_ready;
    logic [CNT_W-1:0] io_cmd_bits_count;
    logic [GAP_W-1:0] io_cmd_bits_gap;
    logic             io_abort;
    logic             io_enq_valid;
    logic             io_enq_ready;
    logic             io_done;
    logic             io_done_aborted;
    logic             io_busy;
    logic [CNT_W-1:0] io_issued;

    logic [CNT_W:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cur_gap  = 0;

    token_burst_issuer #(
        .CNT_W(CNT_W),
        .GAP_W(GAP_W)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .io_cmd_valid      (io_cmd_valid),
        .io_cmd_ready      (io_cmd_ready),
        .io_cmd_bits_count (io_cmd_bits_count),
        .io_cmd_bits_gap   (io_cmd_bits_gap),
        .io_abort          (io_abort),
        .io_enq_valid      (io_enq_valid),
        .io_enq_ready      (io_enq_ready),
        .io_done           (io_done),
        .io_done_aborted   (io_done_aborted),
        .io_busy           (io_busy),
        .io_issued         (io_issued)
    );

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks so far %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Driver: one burst, outcome predicted from the command and abort plan.
    // abort_k < 0: no abort; otherwise abort is pulsed in the cycle after the
    // abort_k-th accepted token (k=0: the cycle right after the command).
    task automatic run_burst(input int cnt, input int gp, input int rdy_delay,
                             input int rnd, input int abort_k);
        int  e_iss;
        bit  e_ab;
        bit  gap_abort;
        int  hs_cnt;
        int  cyc;
        bit  got_done;
        bit  abort_sent;
        bit  prev_hs;
        bit  prev_ab;
        bit  hs_now;
        gap_abort = 1'b0;
        if (abort_k < 0 || cnt == 0) begin
            e_iss = cnt; e_ab = 1'b0;
        end else if (abort_k == 0 || gp == 0) begin
            e_iss = abort_k + 1; e_ab = (abort_k + 1 < cnt);
        end else begin
            e_iss = abort_k; e_ab = 1'b1; gap_abort = 1'b1;
        end

        @(posedge clock); #2;
        io_cmd_valid      = 1'b1;
        io_cmd_bits_count = CNT_W'(cnt);
        io_cmd_bits_gap   = GAP_W'(gp);
        cur_gap           = gp;
        exp_q.push_back({e_ab, e_iss[CNT_W-1:0]});
        @(negedge clock);
        check("cmd_ready_at_cmd", io_cmd_ready, 1);
        @(posedge clock); #2;
        io_cmd_valid = 1'b0;
        hs_cnt = 0; cyc = 0; got_done = 0; abort_sent = 0; prev_hs = 0; prev_ab = 0;
        if (abort_k == 0 && cnt > 0) begin
            io_abort = 1'b1; abort_sent = 1'b1;
        end
        while (!got_done && cyc < 2000) begin
            io_enq_ready = (cyc >= rdy_delay) && ((rnd == 0) || ($urandom_range(0, 3) != 0));
            @(negedge clock);
            check("issued_running", io_issued, hs_cnt);
            hs_now = io_enq_valid && io_enq_ready;
            if (io_done) begin
                got_done = 1'b1;
                check("done_timing",
                      (cnt == 0) ? (cyc == 0) : (gap_abort ? prev_ab : prev_hs), 1);
            end
            if (hs_now) hs_cnt++;
            prev_hs = hs_now;
            prev_ab = io_abort;
            @(posedge clock); #2;
            io_abort = 1'b0;
            if (!abort_sent && abort_k > 0 && hs_cnt == abort_k) begin
                io_abort = 1'b1; abort_sent = 1'b1;
            end
            cyc++;
        end
        if (!got_done) check("burst_timeout", got_done, 1);
        io_enq_ready = 1'b0;
        io_abort     = 1'b0;
    endtask

    task automatic reset_mid_burst();
        @(posedge clock); #2;
        io_cmd_valid      = 1'b1;
        io_cmd_bits_count = CNT_W'(10);
        io_cmd_bits_gap   = '0;
        cur_gap           = 0;
        io_enq_ready      = 1'b0;
        @(posedge clock); #2;
        io_cmd_valid = 1'b0;
        io_enq_ready = 1'b1;
        repeat (2) @(posedge clock);
        #3;
        check("pre_reset_valid", io_enq_valid, 1);
        reset = 1'b0;
        #1;
        check("reset_valid_async", io_enq_valid, 0);
        check("reset_busy_async", io_busy, 0);
        repeat (2) @(posedge clock);
        #2;
        reset        = 1'b1;
        io_enq_ready = 1'b0;
        @(negedge clock);
        check("post_reset_cmd_ready", io_cmd_ready, 1);
        check("post_reset_issued", io_issued, 0);
        check("post_reset_done", io_done, 0);
    endtask

    // Monitor / scoreboard
    bit             m_prev_v, m_prev_r, m_after_hs, m_exp_v_next;
    int             m_idle_run;
    logic [CNT_W:0] m_exp;

    initial begin
        m_prev_v = 0; m_prev_r = 0; m_after_hs = 0; m_exp_v_next = 0; m_idle_run = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                m_prev_v = 0; m_after_hs = 0; m_exp_v_next = 0;
                continue;
            end
            check("cmd_ready_vs_busy", io_cmd_ready, !io_busy);
            if (io_done_aborted) check("aborted_implies_done", io_done, 1);
            if (io_enq_valid) check("valid_implies_busy", io_busy, 1);
            if (m_prev_v && !m_prev_r) check("valid_held", io_enq_valid, 1);
            if (m_exp_v_next) check("first_valid_latency", io_enq_valid, 1);
            m_exp_v_next = 0;
            if (m_after_hs) begin
                if (io_enq_valid) begin
                    check("gap_len", m_idle_run, cur_gap);
                    m_after_hs = 0;
                end else if (io_busy) begin
                    m_idle_run++;
                end else begin
                    m_after_hs = 0;
                end
            end
            if (io_done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", exp_q.size(), 1);
                end else begin
                    m_exp = exp_q.pop_front();
                    check("done_issued", io_issued, m_exp[CNT_W-1:0]);
                    check("done_aborted", io_done_aborted, m_exp[CNT_W]);
                end
            end
            if (io_cmd_valid && io_cmd_ready && io_cmd_bits_count != '0) m_exp_v_next = 1;
            if (io_enq_valid && io_enq_ready) begin
                m_after_hs = 1; m_idle_run = 0;
            end
            m_prev_v = io_enq_valid;
            m_prev_r = io_enq_ready;
        end
    end

    // Main sequence
    initial begin
        int cnt, gp, ak;
        reset             = 1'b0;
        io_cmd_valid      = 1'b1;
        io_cmd_bits_count = CNT_W'(3);
        io_cmd_bits_gap   = '0;
        io_abort          = 1'b0;
        io_enq_ready      = 1'b0;
        #1;
        check("reset_cmd_ready", io_cmd_ready, 1);
        check("reset_enq_valid", io_enq_valid, 0);
        check("reset_done", io_done, 0);
        check("reset_done_aborted", io_done_aborted, 0);
        check("reset_busy", io_busy, 0);
        check("reset_issued", io_issued, 0);
        repeat (3) @(posedge clock);
        #2;
        io_cmd_valid = 1'b0;
        reset        = 1'b1;
        @(negedge clock);
        check("no_capture_in_reset", io_busy, 0);

        run_burst(3, 0, 0, 0, -1);
        run_burst(2, 2, 0, 0, -1);
        run_burst(4, 0, 5, 0, -1);
        run_burst(5, 3, 0, 0, 1);
        run_burst(5, 0, 3, 0, 0);
        run_burst(0, 0, 0, 0, -1);
        run_burst(1, 5, 0, 0, 0);
        run_burst(3, 15, 0, 0, -1);
        run_burst(255, 0, 0, 0, -1);
        reset_mid_burst();
        run_burst(2, 1, 0, 0, -1);

        for (int i = 0; i < 60; i++) begin
            cnt = $urandom_range(0, 12);
            gp  = $urandom_range(0, 3);
            ak  = -1;
            if (cnt > 0 && $urandom_range(0, 2) == 0) ak = $urandom_range(0, cnt - 1);
            run_burst(cnt, gp, $urandom_range(0, 2), 1, ak);
        end

        repeat (4) @(posedge clock);
        @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/token_burst_issuer.md
Name: token_burst_issuer

Overview:
- Producer end of the team's dataless token enqueue handshake (valid/ready, no payload).
- Accepts a burst command (token count plus an optional inter-token gap) and drives enq_valid until that many handshakes complete with the downstream token queue.
- Sits in front of single- or multi-entry token queues used for credit and occupancy tracking.
- Reports completion, abort status, and a running issued count.

Parameters:
- CNT_W, 8, width of burst count and issued counter (max burst 2^CNT_W-1).
- GAP_W, 4, width of inter-token idle-gap field in cycles.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_cmd_valid  input  1  burst command offered.
- io_cmd_ready  output  1  issuer idle and able to accept a command.
- io_cmd_bits_count  input  CNT_W  number of tokens to issue.
- io_cmd_bits_gap  input  GAP_W  idle cycles inserted after each accepted token except the last.
- io_abort  input  1  request early termination of the current burst.
- io_enq_valid  output  1  token offered downstream.
- io_enq_ready  input  1  downstream accepts the token.
- io_done  output  1  one-cycle pulse when a burst ends.
- io_done_aborted  output  1  qualifies io_done: burst ended by abort.
- io_busy  output  1  burst in progress (state != IDLE).
- io_issued  output  CNT_W  tokens handshaked in current/last burst.

Behaviour:
- Reset (reset low, asynchronous assert, synchronous release):
  - state=IDLE; remaining, gap counter and io_issued = 0.
  - io_enq_valid=0, io_done=0, io_done_aborted=0, io_busy=0.
  - io_cmd_ready=1, but no command is captured while reset is low.
- Handshakes:
  - Command handshake = io_cmd_valid & io_cmd_ready.
  - Token handshake = io_enq_valid & io_enq_ready.
- io_cmd_ready = (state==IDLE). It is combinational from state only, never from io_cmd_valid.
- States: IDLE, ISSUE, GAP.
- IDLE:
  - On a command handshake, latch count, gap and clear io_issued.
  - count==0: stay IDLE; io_done=1 next cycle, io_done_aborted=0.
  - count>0: go to ISSUE. io_enq_valid first rises in the cycle after the command handshake (1-cycle latency).
- ISSUE:
  - io_enq_valid=1. It must not drop until a token handshake occurs.
  - On a token handshake: io_issued+1 and remaining-1.
  - If remaining was 1, or an abort is pending: go to IDLE and pulse io_done next cycle.
  - Else if gap>0: go to GAP with the gap counter set to gap.
  - Else stay in ISSUE, giving back-to-back tokens every cycle while ready stays high.
- GAP:
  - io_enq_valid=0; gap counter decrements each cycle.
  - Go to ISSUE in the cycle after the counter reads 1, so exactly `gap` idle cycles occur.
- Abort:
  - io_abort is sampled every cycle and sets a sticky abort_pending; it is ignored in IDLE.
  - In GAP, abort_pending takes effect immediately: next state IDLE, io_done=1, io_done_aborted=1.
  - In ISSUE, the outstanding token is never withdrawn. Abort takes effect at the next token handshake (that token counts in io_issued).
  - If that handshake was also the last token, io_done_aborted=0.
  - abort_pending is cleared on entry to IDLE.
- io_done/io_done_aborted:
  - Registered pulses, exactly one cycle per burst.
  - io_done_aborted is only ever high together with io_done.
- io_issued holds its final value after a burst until the next command handshake.
- Arithmetic: all counters are unsigned CNT_W/GAP_W with no wrap. remaining is never decremented below 1 while in ISSUE.
- Reset mid-burst: io_enq_valid drops asynchronously and no io_done is produced; the downstream queue must be reset in the same domain.

Decomposition:
- Package token_issuer_pkg:
  - state enum {IDLE, ISSUE, GAP} (2-bit encoding).
  - Default CNT_W/GAP_W localparams.
- One sub-module: token_gap_timer. It is a loadable down-counter with load, count and expired outputs, reused by the GAP state.

Test Plan:
- count=3, gap=0, ready held 1: enq_valid high for 3 consecutive cycles starting 1 cycle after the cmd handshake. io_issued=3; io_done pulses the cycle after the 3rd handshake; io_done_aborted=0.
- count=2, gap=2, ready=1: valid pattern is 1,0,0,1, then done. io_busy high throughout, io_cmd_ready low until done.
- count=4, ready=0 for 5 cycles then 1: valid held high and stable while ready=0; io_issued stays 0 until ready rises; burst then completes with io_issued=4.
- count=5, gap=3, abort pulsed during the first GAP: next cycle io_done=1, io_done_aborted=1, io_issued=1, io_enq_valid never reasserts.
- count=5, ready=0, abort pulsed in ISSUE, ready=1 two cycles later: valid not withdrawn; one handshake, then io_done with aborted=1 and io_issued=1.
- count=0 command; separately, reset driven low mid-burst: count=0 gives io_done the next cycle, no valid, state IDLE. Reset low makes valid fall immediately; after release io_cmd_ready=1 and io_issued=0.
